// File: rtl/bus_cycle_master_if.sv
// Core-side request/response handshake and multiplexed AD peripheral bus.
// The master modport is the bus_cycle_master view; slave is the environment.
interface bus_cycle_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_we;
    logic [DATA_W-1:0] resp_rdata;
    logic              ALE;
    logic              CS;
    logic              rdb;
    logic              wrb;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;
    logic [DATA_W-1:0] ad_in;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, ad_in,
        output req_ready, resp_valid, resp_we, resp_rdata,
        output ALE, CS, rdb, wrb, ad_out, ad_oe
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, ad_in,
        input  req_ready, resp_valid, resp_we, resp_rdata,
        input  ALE, CS, rdb, wrb, ad_out, ad_oe
    );
endinterface

// File: rtl/bus_cycle_master.sv
// Single-beat bus cycle master: address phase, strobe phase, recovery.
// One transaction in flight; completion reported as a 1-cycle pulse.
module bus_cycle_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STROBE_CYC = 2
) (
    input  logic                clock,
    input  logic                reset,
    bus_cycle_master_if.master  bus
);
    localparam int CNT_W = $clog2(STROBE_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STROBE_CYC - 1);

    if (STROBE_CYC < 2 || STROBE_CYC > 15 || ADDR_W > DATA_W) begin : g_bad_cfg
        $error("bus_cycle_master: illegal STROBE_CYC or ADDR_W > DATA_W");
    end

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        ADDR    = 4'b0010,
        STROBE  = 4'b0100,
        RECOVER = 4'b1000
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  strb_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic              last_strb;

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign accept         = bus.req_valid && bus.req_ready;
    assign last_strb      = (state == STROBE) && (strb_cnt == LAST);
    assign bus.resp_rdata = rdata_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state sequencing
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = ADDR;
            ADDR:    state_next = STROBE;
            STROBE:  if (strb_cnt == LAST) state_next = RECOVER;
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, strobe counter and read data capture
    always_ff @(posedge clock) begin
        if (reset) begin
            strb_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                we_q    <= bus.req_we;
            end
            if (state == ADDR)
                strb_cnt <= '0;
            else if (state == STROBE)
                strb_cnt <= strb_cnt + CNT_W'(1);
            if (last_strb && !we_q)
                rdata_q <= bus.ad_in;
        end
    end

    // Moore decode of bus and response outputs from the registered state
    always_comb begin
        bus.ALE        = 1'b0;
        bus.CS         = 1'b0;
        bus.rdb        = 1'b1;
        bus.wrb        = 1'b1;
        bus.ad_oe      = 1'b0;
        bus.ad_out     = '0;
        bus.resp_valid = 1'b0;
        bus.resp_we    = 1'b0;
        unique case (state)
            ADDR: begin
                bus.ALE    = 1'b1;
                bus.CS     = 1'b1;
                bus.ad_oe  = 1'b1;
                bus.ad_out = DATA_W'(addr_q);
            end
            STROBE: begin
                bus.CS = 1'b1;
                if (we_q) begin
                    bus.wrb    = 1'b0;
                    bus.ad_oe  = 1'b1;
                    bus.ad_out = wdata_q;
                end else begin
                    bus.rdb = 1'b0;
                end
            end
            RECOVER: begin
                bus.resp_valid = 1'b1;
                bus.resp_we    = we_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bus_cycle_master.sv
// Directed test of bus_cycle_master with STROBE_CYC=2 and STROBE_CYC=4.
// Expected values are hand-computed cycle by cycle from the accept edge.
module tb_bus_cycle_master;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    bus_cycle_master_if #(.ADDR_W(8), .DATA_W(8)) a ();
    bus_cycle_master_if #(.ADDR_W(8), .DATA_W(8)) b ();

    bus_cycle_master #(.ADDR_W(8), .DATA_W(8), .STROBE_CYC(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (a)
    );

    bus_cycle_master #(.ADDR_W(8), .DATA_W(8), .STROBE_CYC(4)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (b)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle_a(input string tag);
        check({tag, ".ALE"}, a.ALE, 1'b0);
        check({tag, ".CS"}, a.CS, 1'b0);
        check({tag, ".rdb"}, a.rdb, 1'b1);
        check({tag, ".wrb"}, a.wrb, 1'b1);
        check({tag, ".ad_oe"}, a.ad_oe, 1'b0);
        check({tag, ".ad_out"}, a.ad_out, 8'h00);
        check({tag, ".resp_valid"}, a.resp_valid, 1'b0);
    endtask

    initial begin
        a.req_valid = 1'b1;
        a.req_we    = 1'b1;
        a.req_addr  = 8'h77;
        a.req_wdata = 8'h11;
        a.ad_in     = 8'h00;
        b.req_valid = 1'b0;
        b.req_we    = 1'b0;
        b.req_addr  = 8'h00;
        b.req_wdata = 8'h00;
        b.ad_in     = 8'h00;

        // 1: reset held 2 cycles with a request pending
        tick();
        check("rst1.ready", a.req_ready, 1'b0);
        chk_idle_a("rst1");
        tick();
        check("rst2.ready", a.req_ready, 1'b0);
        chk_idle_a("rst2");
        check("rst2.resp_we", a.resp_we, 1'b0);
        check("rst2.rdata", a.resp_rdata, 8'h00);
        a.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst.ready_after", a.req_ready, 1'b1);

        // 2: write 12 <- A5
        a.req_valid = 1'b1;
        a.req_we    = 1'b1;
        a.req_addr  = 8'h12;
        a.req_wdata = 8'hA5;
        tick();
        a.req_valid = 1'b0;
        check("wr.c1.ALE", a.ALE, 1'b1);
        check("wr.c1.CS", a.CS, 1'b1);
        check("wr.c1.ad_oe", a.ad_oe, 1'b1);
        check("wr.c1.ad_out", a.ad_out, 8'h12);
        check("wr.c1.ready", a.req_ready, 1'b0);
        tick();
        check("wr.c2.ALE", a.ALE, 1'b0);
        check("wr.c2.wrb", a.wrb, 1'b0);
        check("wr.c2.rdb", a.rdb, 1'b1);
        check("wr.c2.ad_out", a.ad_out, 8'hA5);
        check("wr.c2.ad_oe", a.ad_oe, 1'b1);
        tick();
        check("wr.c3.wrb", a.wrb, 1'b0);
        check("wr.c3.ad_out", a.ad_out, 8'hA5);
        check("wr.c3.resp_valid", a.resp_valid, 1'b0);
        tick();
        check("wr.c4.resp_valid", a.resp_valid, 1'b1);
        check("wr.c4.resp_we", a.resp_we, 1'b1);
        check("wr.c4.rdata", a.resp_rdata, 8'h00);
        check("wr.c4.wrb", a.wrb, 1'b1);
        check("wr.c4.CS", a.CS, 1'b0);
        check("wr.c4.ad_oe", a.ad_oe, 1'b0);
        tick();
        check("wr.c5.resp_valid", a.resp_valid, 1'b0);
        check("wr.c5.ready", a.req_ready, 1'b1);

        // 3: read 34, slave drives 5C from the second strobe cycle
        a.req_valid = 1'b1;
        a.req_we    = 1'b0;
        a.req_addr  = 8'h34;
        a.ad_in     = 8'hEE;
        tick();
        a.req_valid = 1'b0;
        check("rd.c1.ALE", a.ALE, 1'b1);
        check("rd.c1.ad_out", a.ad_out, 8'h34);
        tick();
        check("rd.c2.rdb", a.rdb, 1'b0);
        check("rd.c2.wrb", a.wrb, 1'b1);
        check("rd.c2.ad_oe", a.ad_oe, 1'b0);
        check("rd.c2.CS", a.CS, 1'b1);
        a.ad_in = 8'h5C;
        tick();
        check("rd.c3.rdb", a.rdb, 1'b0);
        check("rd.c3.ad_oe", a.ad_oe, 1'b0);
        tick();
        check("rd.c4.resp_valid", a.resp_valid, 1'b1);
        check("rd.c4.resp_we", a.resp_we, 1'b0);
        check("rd.c4.rdata", a.resp_rdata, 8'h5C);
        check("rd.c4.rdb", a.rdb, 1'b1);
        tick();
        check("rd.c5.rdata_hold", a.resp_rdata, 8'h5C);
        check("rd.c5.resp_valid", a.resp_valid, 1'b0);

        // 4: back-to-back write then read with req_valid held
        a.req_valid = 1'b1;
        a.req_we    = 1'b1;
        a.req_addr  = 8'h56;
        a.req_wdata = 8'h3C;
        a.ad_in     = 8'h99;
        tick();
        check("b2b.c1.ALE", a.ALE, 1'b1);
        check("b2b.c1.ready", a.req_ready, 1'b0);
        a.req_we   = 1'b0;
        a.req_addr = 8'h78;
        tick();
        check("b2b.c2.ALE", a.ALE, 1'b0);
        check("b2b.c2.ready", a.req_ready, 1'b0);
        tick();
        check("b2b.c3.ALE", a.ALE, 1'b0);
        check("b2b.c3.ready", a.req_ready, 1'b0);
        tick();
        check("b2b.c4.ALE", a.ALE, 1'b0);
        check("b2b.c4.ready", a.req_ready, 1'b0);
        check("b2b.c4.resp_valid", a.resp_valid, 1'b1);
        check("b2b.c4.rdata_kept", a.resp_rdata, 8'h5C);
        tick();
        check("b2b.c5.ALE", a.ALE, 1'b0);
        check("b2b.c5.ready", a.req_ready, 1'b1);
        tick();
        a.req_valid = 1'b0;
        check("b2b.c6.ALE", a.ALE, 1'b1);
        check("b2b.c6.ad_out", a.ad_out, 8'h78);
        tick();
        tick();
        tick();
        check("b2b.c9.resp_valid", a.resp_valid, 1'b1);
        check("b2b.c9.rdata", a.resp_rdata, 8'h99);
        tick();

        // 5: reset during the strobe phase of a read
        a.req_valid = 1'b1;
        a.req_we    = 1'b0;
        a.req_addr  = 8'h9A;
        a.ad_in     = 8'h42;
        tick();
        a.req_valid = 1'b0;
        tick();
        check("mid.c2.rdb", a.rdb, 1'b0);
        reset = 1'b1;
        tick();
        check("mid.CS", a.CS, 1'b0);
        check("mid.rdb", a.rdb, 1'b1);
        check("mid.resp_valid", a.resp_valid, 1'b0);
        check("mid.rdata", a.resp_rdata, 8'h00);
        reset = 1'b0;
        #1;
        check("mid.ready", a.req_ready, 1'b1);
        tick();
        check("mid.n1.resp_valid", a.resp_valid, 1'b0);
        tick();
        check("mid.n2.resp_valid", a.resp_valid, 1'b0);
        check("mid.n2.rdata", a.resp_rdata, 8'h00);

        // 6: STROBE_CYC=4 read, sample on the 4th strobe edge
        b.req_valid = 1'b1;
        b.req_we    = 1'b0;
        b.req_addr  = 8'h21;
        b.ad_in     = 8'h10;
        tick();
        b.req_valid = 1'b0;
        check("s4.c1.ALE", b.ALE, 1'b1);
        tick();
        check("s4.c2.rdb", b.rdb, 1'b0);
        check("s4.c2.ad_oe", b.ad_oe, 1'b0);
        tick();
        check("s4.c3.rdb", b.rdb, 1'b0);
        tick();
        check("s4.c4.rdb", b.rdb, 1'b0);
        b.ad_in = 8'h6B;
        tick();
        check("s4.c5.rdb", b.rdb, 1'b0);
        check("s4.c5.resp_valid", b.resp_valid, 1'b0);
        tick();
        check("s4.c6.resp_valid", b.resp_valid, 1'b1);
        check("s4.c6.rdata", b.resp_rdata, 8'h6B);
        check("s4.c6.rdb", b.rdb, 1'b1);
        tick();
        check("s4.c7.resp_valid", b.resp_valid, 1'b0);
        check("s4.c7.ready", b.req_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
